// File: rtl/ebi_pkg.sv
// rtl/ebi_pkg.sv - shared constants and FSM state encoding for the EBI slave controller
package ebi_pkg;

    localparam int EBI_DATA_W = 16;
    localparam int EBI_ADDR_W = 25;

    // Read-back values for reads that never reached a register.
    localparam logic [EBI_DATA_W-1:0] EBI_TIMEOUT_DATA = 16'hDEAD;
    localparam logic [EBI_DATA_W-1:0] EBI_OOR_DATA     = 16'hBAD0;

    localparam logic [2:0] ST_IDLE     = 3'd0;
    localparam logic [2:0] ST_REQ      = 3'd1;
    localparam logic [2:0] ST_WAIT_ACK = 3'd2;
    localparam logic [2:0] ST_DRIVE    = 3'd3;
    localparam logic [2:0] ST_RELEASE  = 3'd4;

endpackage

// File: rtl/ebi_sync.sv
// rtl/ebi_sync.sv - N-flop synchronizer with level and falling-edge outputs
//
// Ports:
//   clk_i    system clock
//   reset_i  synchronous active-low reset
//   d_i      asynchronous input
//   level_o  synchronized level (last stage)
//   fall_o   one-cycle pulse when the synchronized level goes 1 -> 0
module ebi_sync #(
    parameter int STAGES = 2
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic level_o,
    output logic fall_o
);

    logic [STAGES-1:0] stage;
    logic              started;
    logic              armed;

    // The chain resets to 1, so an input already low at reset release would
    // otherwise look like a falling edge. The edge output is armed only once
    // the input has been seen high after reset.
    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            stage   <= '1;
            started <= 1'b0;
            armed   <= 1'b0;
        end else begin
            stage   <= {stage[STAGES-2:0], d_i};
            started <= 1'b1;
            armed   <= armed | (started & stage[0]);
        end
    end

    assign level_o = stage[STAGES-1];
    assign fall_o  = armed & stage[STAGES-1] & ~stage[STAGES-2];

endmodule

// File: rtl/ebi_bus_ctrl.sv
// rtl/ebi_bus_ctrl.sv - EBI/SMC slave: strobe sync, address decode, register-bus handshake, pad enable
//
// Ports:
//   clk_i, reset_i              clock, synchronous active-low reset
//   addr_i, cs_i, read_i,
//   write_i                     asynchronous EBI pins (strobes active-low)
//   data_to_iface_i             data from the pad buffer
//   data_from_iface_o           data to the pad buffer
//   disable_io_o                pad tristate control, 1 = released
//   reg_addr_o, reg_wdata_o,
//   reg_re_o, reg_we_o          internal register request
//   reg_rdata_i, reg_ack_i      internal register response
//   err_clr_i, err_o            sticky timeout/protocol error flag and its clear
module ebi_bus_ctrl
    import ebi_pkg::*;
#(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 64
) (
    input  logic                  clk_i,
    input  logic                  reset_i,
    input  logic [EBI_ADDR_W-1:0] addr_i,
    input  logic                  cs_i,
    input  logic                  read_i,
    input  logic                  write_i,
    input  logic [EBI_DATA_W-1:0] data_to_iface_i,
    output logic [EBI_DATA_W-1:0] data_from_iface_o,
    output logic                  disable_io_o,
    output logic [ADDR_W-1:0]     reg_addr_o,
    output logic [EBI_DATA_W-1:0] reg_wdata_o,
    output logic                  reg_re_o,
    output logic                  reg_we_o,
    input  logic [EBI_DATA_W-1:0] reg_rdata_i,
    input  logic                  reg_ack_i,
    input  logic                  err_clr_i,
    output logic                  err_o
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [2:0]       state;
    logic             acc_rd;
    logic [CNT_W-1:0] wait_cnt;

    logic cs_lvl, cs_fall;
    logic rd_lvl, rd_fall;
    logic wr_lvl, wr_fall;
    logic out_of_window;
    logic unused_ok;

    ebi_sync #(.STAGES(3)) u_sync_cs (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (cs_i),
        .level_o (cs_lvl),
        .fall_o  (cs_fall)
    );

    ebi_sync #(.STAGES(2)) u_sync_rd (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (read_i),
        .level_o (rd_lvl),
        .fall_o  (rd_fall)
    );

    ebi_sync #(.STAGES(2)) u_sync_wr (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (write_i),
        .level_o (wr_lvl),
        .fall_o  (wr_fall)
    );

    // 16-bit bus: addr_i[0] is a byte lane bit and carries no word address.
    assign unused_ok     = &{1'b0, addr_i[0], rd_fall, wr_fall};
    assign out_of_window = |addr_i[EBI_ADDR_W-1:ADDR_W+1];

    // Uses the raw pins so the pads release within gate delay of the host
    // deasserting, without waiting for the synchronizers.
    assign disable_io_o = (state != ST_DRIVE) | read_i | cs_i;

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            state             <= ST_IDLE;
            acc_rd            <= 1'b0;
            wait_cnt          <= '0;
            data_from_iface_o <= '0;
            reg_addr_o        <= '0;
            reg_wdata_o       <= '0;
            reg_re_o          <= 1'b0;
            reg_we_o          <= 1'b0;
            err_o             <= 1'b0;
        end else begin
            reg_re_o <= 1'b0;
            reg_we_o <= 1'b0;
            // Any set below is a later assignment and therefore wins.
            if (err_clr_i) begin
                err_o <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (cs_fall) begin
                        reg_addr_o  <= addr_i[ADDR_W:1];
                        reg_wdata_o <= data_to_iface_i;
                        acc_rd      <= ~rd_lvl;
                        if (rd_lvl == wr_lvl) begin
                            err_o <= 1'b1;
                            state <= ST_RELEASE;
                        end else if (out_of_window) begin
                            if (!rd_lvl) begin
                                data_from_iface_o <= EBI_OOR_DATA;
                                state             <= ST_DRIVE;
                            end else begin
                                state <= ST_RELEASE;
                            end
                        end else begin
                            reg_re_o <= ~rd_lvl;
                            reg_we_o <= ~wr_lvl;
                            state    <= ST_REQ;
                        end
                    end
                end

                ST_REQ: begin
                    wait_cnt <= '0;
                    if (reg_ack_i) begin
                        if (acc_rd) begin
                            data_from_iface_o <= reg_rdata_i;
                            state             <= ST_DRIVE;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end else begin
                        state <= ST_WAIT_ACK;
                    end
                end

                ST_WAIT_ACK: begin
                    if (reg_ack_i) begin
                        wait_cnt <= '0;
                        if (acc_rd) begin
                            data_from_iface_o <= reg_rdata_i;
                            state             <= ST_DRIVE;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end else if (wait_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        wait_cnt <= '0;
                        err_o    <= 1'b1;
                        if (acc_rd) begin
                            data_from_iface_o <= EBI_TIMEOUT_DATA;
                            state             <= ST_DRIVE;
                        end else begin
                            state <= ST_RELEASE;
                        end
                    end else begin
                        wait_cnt <= wait_cnt + CNT_W'(1);
                    end
                end

                ST_DRIVE, ST_RELEASE: begin
                    if (cs_lvl) begin
                        state <= ST_IDLE;
                    end
                end

                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/ebi_bus_ctrl.md
# ebi_bus_ctrl

Slave-side controller for the AT91SAM9G45 static-memory (EBI/SMC) bus into the FPGA. It synchronizes the asynchronous chip-select and read/write strobes and decodes the address. Each external access becomes exactly one request/acknowledge transaction on an internal register bus. It also sequences the tristate data-pad enable, so the FPGA drives the shared bus only during a valid read.

## Interface
Parameters:
- ADDR_W, 8: internal register word-address width; window is addr_i[ADDR_W:1], addr_i[0] ignored (16-bit bus)
- TIMEOUT_CYCLES, 64: max cycles to wait for reg_ack_i before abandoning the request

Ports:
- clk_i  in  1  single system clock; all logic on its rising edge
- reset_i  in  1  synchronous, active-low reset
- addr_i  in  25  EBI address, async
- cs_i  in  1  EBI chip select, active-low, async
- read_i  in  1  EBI read strobe (NRD), active-low, async
- write_i  in  1  EBI write strobe (NWE), active-low, async
- data_to_iface_i  in  16  data from pad IOBUF O
- data_from_iface_o  out  16  data to pad IOBUF I
- disable_io_o  out  1  pad IOBUF T; 1 = FPGA tristated
- reg_addr_o  out  ADDR_W  internal register word address
- reg_wdata_o  out  16  internal write data
- reg_re_o  out  1  read request, one-cycle pulse
- reg_we_o  out  1  write request, one-cycle pulse
- reg_rdata_i  in  16  internal read data, valid when reg_ack_i=1
- reg_ack_i  in  1  request completion, may be same cycle as request
- err_clr_i  in  1  clears err_o
- err_o  out  1  sticky: timeout or protocol error

## Operation
- cs_i passes through a 3-flop chain (s1, s2, s3). The access start is s2=0, s3=1 (falling edge). read_i and write_i each pass through 2-flop synchronizers.
- States:
  - IDLE
  - REQ
  - WAIT_ACK
  - DRIVE
  - RELEASE
- IDLE, on cs falling edge:
  - Latch addr_i, data_to_iface_i and the synchronized rd/wr.
  - Classify the access:
    - rd low only: read.
    - wr low only: write.
    - Both low, or neither low: protocol error. Set err_o and go to RELEASE.
  - Out-of-window address (addr_i[24:ADDR_W+1] != 0):
    - Read: load data_from_iface_o=16'hBAD0 and go to DRIVE.
    - Write: drop it and go to RELEASE.
    - No reg request in either case.
- REQ: assert reg_re_o or reg_we_o for exactly one cycle, with reg_addr_o and reg_wdata_o stable. If reg_ack_i is seen in this cycle, skip WAIT_ACK.
- WAIT_ACK:
  - Count cycles.
  - On reg_ack_i: a read loads data_from_iface_o <= reg_rdata_i and goes to DRIVE; a write goes to RELEASE.
  - When the count reaches TIMEOUT_CYCLES: set err_o. A read loads 16'hDEAD and goes to DRIVE; a write goes to RELEASE.
- DRIVE: hold data until synchronized cs is high, then return to IDLE.
- RELEASE: wait for synchronized cs high, then return to IDLE.
- disable_io_o = !(state==DRIVE) | read_i | cs_i. It is combinational on the raw pins, so the bus is released within gate delay when the host deasserts.
- reg_addr_o, reg_wdata_o and data_from_iface_o hold their values between accesses.
- err_o:
  - Set by timeout or protocol error.
  - Cleared by err_clr_i.
  - If set and clear arrive in the same cycle, set wins.
- A new cs falling edge is accepted only in IDLE. Edges seen in other states are ignored; cs must return high first.

## Timing
- Pad cs/rd low at cycle 0 → edge detected at cycle 2 → REQ at cycle 3. With same-cycle ack, DRIVE starts at cycle 4 and data is on the pads at cycle 4.
- Out-of-window read reaches DRIVE at cycle 3.
- Required SMC setting: NRD pulse ≥ 6 clk cycles plus the reg bus ack latency. Writes need NWE pulse ≥ 3 clk cycles.
- Address and data are sampled at cycle 2; the SMC setup must keep them stable from cs fall through cycle 2.
- Minimum spacing between accesses: cs high ≥ 3 clk cycles.
- Reset values:
  - state = IDLE
  - sync flops = 1
  - data_from_iface_o = 0
  - reg_addr_o = 0
  - reg_wdata_o = 0
  - reg_re_o = 0
  - reg_we_o = 0
  - err_o = 0
  - disable_io_o = 1
  - timeout counter = 0
- Reset asserted mid-access: abort immediately with no request pulse, and the next cycle is IDLE. If cs is already low when reset releases, no edge is seen and the access is ignored.

## Structure
- Package ebi_pkg holds:
  - state encoding
  - constants EBI_DATA_W=16, EBI_ADDR_W=25
  - EBI_TIMEOUT_DATA=16'hDEAD, EBI_OOR_DATA=16'hBAD0
- Sub-module ebi_sync: N-flop synchronizer with a falling-edge output. It is used for cs (3 stages, edge output) and for rd/wr (2 stages, level output).
- The FSM, timeout counter and error logic live in ebi_bus_ctrl.

## Test plan
- Read, addr 0x000004, reg_ack_i same cycle, reg_rdata_i=16'h1234 → one reg_re_o pulse with reg_addr_o=2; data_from_iface_o=16'h1234 and disable_io_o=0 from cycle 4 until read_i rises.
- Write 16'hCAFE to addr 0x000010, ack after 5 cycles → one reg_we_o pulse, reg_addr_o=8, reg_wdata_o=16'hCAFE; disable_io_o stays 1 throughout.
- Read with reg_ack_i never asserted → err_o set after 64 cycles in WAIT_ACK; pads drive 16'hDEAD; err_clr_i clears err_o.
- Read at addr 0x100000 (out of window) → no reg_re_o; pads drive 16'hBAD0; write to the same address → no reg_we_o, err_o stays 0.
- read_i and write_i both low with cs low → no request, err_o=1, disable_io_o=1.
- Reset asserted during WAIT_ACK, then cs toggled high→low → state returns to IDLE, outputs at reset values, and the next access completes normally.
